// File: rtl/text_writer_if.sv
// text_writer_if: groups the byte-stream handshake and the text memory
// port A write bus used by text_writer.
//   char_data/char_valid/char_ready : ASCII byte stream, valid/ready handshake
//   mem_we/mem_addr/mem_din         : text memory port A write side
// Modports:
//   master : byte source side (drives the stream, observes the rest)
//   slave  : text_writer side (consumes the stream, drives port A)
interface text_writer_if #(
    parameter int ADDR_W = 12
) ();
    logic [7:0]        char_data;
    logic              char_valid;
    logic              char_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;

    modport master (
        output char_data, char_valid,
        input  char_ready, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  char_data, char_valid,
        output char_ready, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/text_writer.sv
// text_writer: write-side agent for the COLS x ROWS character text memory.
// Accepts ASCII bytes over a valid/ready handshake, interprets a small
// terminal control set (CR, LF, TAB, BS, FF), keeps a cursor and writes
// printable bytes at row*COLS+col. FF (and optionally reset) runs a
// full-screen clear that writes FILL_CHAR to every cell.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   bus         : text_writer_if.slave (byte stream in, port A write bus out)
//   cursor_col  : current cursor column, 0..COLS-1
//   cursor_row  : current cursor row, 0..ROWS-1
//   busy        : clear sequence in progress
// All outputs are registered.
module text_writer #(
    parameter int         COLS           = 80,
    parameter int         ROWS           = 30,
    parameter int         ADDR_W         = 12,
    parameter logic [7:0] FILL_CHAR      = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    text_writer_if.slave bus,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic       busy
);
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int     TOTAL     = COLS * ROWS;
    localparam state_e RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic [ADDR_W-1:0] lin_addr;
    logic [4:0]        row_inc;
    logic [7:0]        tab_col;

    // Full-width multiply so row*COLS never truncates before the add.
    assign lin_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
    assign row_inc  = (row_q == 5'(ROWS - 1)) ? '0 : row_q + 5'd1;
    assign tab_col  = ({1'b0, col_q} | 8'd7) + 8'd1;
    assign accept   = ready_q && bus.char_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.char_data >= 8'h20 && bus.char_data <= 8'h7E) begin
                        we_d   = 1'b1;
                        addr_d = lin_addr;
                        din_d  = bus.char_data;
                        if (col_q == 7'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_inc;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (bus.char_data)
                            8'h0D: col_d = '0;
                            8'h0A: begin
                                col_d = '0;
                                row_d = row_inc;
                            end
                            8'h09: begin
                                if (tab_col >= 8'(COLS)) begin
                                    col_d = '0;
                                    row_d = row_inc;
                                end else begin
                                    col_d = tab_col[6:0];
                                end
                            end
                            8'h08: begin
                                // Erase the cell left of the cursor; no reverse row wrap.
                                if (col_q != '0) begin
                                    col_d  = col_q - 7'd1;
                                    we_d   = 1'b1;
                                    addr_d = lin_addr - ADDR_W'(1);
                                    din_d  = FILL_CHAR;
                                end
                            end
                            8'h0C: begin
                                col_d   = '0;
                                row_d   = '0;
                                cnt_d   = '0;
                                state_d = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                din_d  = FILL_CHAR;
                if (cnt_q == ADDR_W'(TOTAL - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ready_q <= (RST_STATE == IDLE);
            busy_q  <= (RST_STATE == CLEAR);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.char_ready = ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_din    = din_q;
    assign cursor_col     = col_q;
    assign cursor_row     = row_q;
    assign busy           = busy_q;
endmodule
